// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory.
// One transaction in flight; data wins unless fetch has waited too long.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic [63:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [3:0] LAT  = 4'(MEM_LAT);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nx;
    logic       own_dm, own_we, own_a2;
    logic [3:0] cnt, starve_cnt;
    logic       if_win, dm_win, issue;
    logic       unused_bits;

    assign unused_bits = ^{if_addr[1:0], dm_addr[2:0]};

    assign if_win = if_req && (!dm_req || starve_cnt >= SMAX);
    assign dm_win = dm_req && !if_win;

    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_valid  = 1'b0;
        dm_valid  = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                // Grant is combinational so an idle port issues with no bubble.
                if (!rst && (if_req || dm_req)) begin
                    issue    = 1'b1;
                    mem_en   = 1'b1;
                    if_gnt   = if_win;
                    dm_gnt   = dm_win;
                    mem_we   = dm_win && dm_we;
                    mem_addr = dm_win ? {dm_addr[63:3], 3'b000}
                                      : {if_addr[63:3], 3'b000};
                    if (dm_win)
                        mem_wdata = dm_wdata;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd1) begin
                    if_valid = !own_dm;
                    dm_valid = own_dm;
                    if (!own_dm)
                        if_rdata = own_a2 ? mem_rdata[63:32]
                                          : mem_rdata[31:0];
                    if (own_dm && !own_we)
                        dm_rdata = mem_rdata;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        stall_if  = if_req && !if_valid;
        stall_mem = dm_req && !dm_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            own_dm     <= 1'b0;
            own_we     <= 1'b0;
            own_a2     <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue) begin
                own_dm <= dm_win;
                own_we <= dm_win && dm_we;
                own_a2 <= if_win && if_addr[2];
                cnt    <= LAT;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with default MEM_LAT=2, STARVE_MAX=4.
// Stimulus pushes expected grant/valid events; a negedge monitor pops them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_gnt;
    logic [63:0] dm_rdata;
    logic        dm_valid;
    logic        mem_en;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
        .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    localparam logic [1:0] K_IG = 2'd0;
    localparam logic [1:0] K_DG = 2'd1;
    localparam logic [1:0] K_IV = 2'd2;
    localparam logic [1:0] K_DV = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] v1;
        logic [63:0] v2;
        logic        we;
    } ev_t;

    ev_t exp_q[$];

    // Memory model: two-cycle read pipeline, writes land in the table.
    logic [63:0] mem_tab [logic [63:0]];
    logic [63:0] pipe0 = '0;
    logic [63:0] pipe1 = '0;
    assign mem_rdata = pipe1;

    function automatic logic [63:0] rd(input logic [63:0] a);
        if (mem_tab.exists(a))
            return mem_tab[a];
        return 64'h0;
    endfunction

    always @(posedge clk) begin
        pipe0 <= (mem_en && !mem_we) ? rd(mem_addr) : 64'h0;
        pipe1 <= pipe0;
        if (mem_en && mem_we)
            mem_tab[mem_addr] = mem_wdata;
    end

    task automatic push(input logic [1:0] k, input logic [63:0] v1,
                        input logic [63:0] v2, input logic we);
        ev_t e;
        e.kind = k;
        e.v1   = v1;
        e.v2   = v2;
        e.we   = we;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        total++;
        if (act === expv)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, expv, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (if_gnt || dm_gnt || if_valid || dm_valid) begin
            ev_t a, e;
            a.kind = if_gnt ? K_IG : dm_gnt ? K_DG : if_valid ? K_IV : K_DV;
            a.v1   = (a.kind == K_IG || a.kind == K_DG) ? mem_addr :
                     if_valid ? {32'h0, if_rdata} : dm_rdata;
            a.v2   = mem_wdata;
            a.we   = mem_we;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: kind %0d v1 %h at %0t",
                         a.kind, a.v1, $time);
            end else begin
                e = exp_q.pop_front();
                if (a == e)
                    passed++;
                else
                    $display("FAIL event: got k%0d %h %h we%0b, expected k%0d %h %h we%0b at %0t",
                             a.kind, a.v1, a.v2, a.we,
                             e.kind, e.v1, e.v2, e.we, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_tab[64'h100] = 64'hAAAA_BBBB_1111_2222;
        mem_tab[64'h200] = 64'h1234_5678_9ABC_DEF0;
        mem_tab[64'h300] = 64'h0BAD_F00D_CAFE_0001;
        mem_tab[64'h308] = 64'h1111_2222_3333_4444;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset state, also with a request pending
        step(); step();
        @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_valids", 64'({if_valid, dm_valid}), 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_stall_if", 64'(stall_if), 64'h0);
        step();
        if_req = 1'b1; if_addr = 64'h104;
        @(negedge clk);
        chk("rst_req_gnt", 64'({if_gnt, mem_en}), 64'h0);
        chk("rst_req_stall_if", 64'(stall_if), 64'h1);

        // IF read of upper word, issued in first cycle out of reset
        step();
        rst = 1'b0;
        push(K_IG, 64'h100, 64'h0, 1'b0);
        push(K_IV, 64'hAAAA_BBBB, 64'h0, 1'b0);
        @(negedge clk);
        chk("if_mem_en", 64'({mem_en, mem_we}), 64'h2);
        step();
        @(negedge clk);
        chk("if_busy_mem", {63'h0, mem_en} | mem_addr, 64'h0);
        chk("if_busy_stall", 64'(stall_if), 64'h1);
        step();
        @(negedge clk);
        chk("if_valid_stall", 64'(stall_if), 64'h0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        chk("if_after_mem_en", 64'(mem_en), 64'h0);

        // Data write, then read back at the earliest re-issue cycle
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'h55;
        push(K_DG, 64'h40, 64'h55, 1'b1);
        push(K_DV, 64'h0, 64'h0, 1'b0);
        step(); step();
        @(negedge clk);
        chk("wr_valid_no_issue", 64'(mem_en), 64'h0);
        step();
        dm_we = 1'b0; dm_wdata = '0;
        push(K_DG, 64'h40, 64'h0, 1'b0);
        push(K_DV, 64'h55, 64'h0, 1'b0);
        @(negedge clk);
        chk("rd_reissue_gnt", 64'(dm_gnt), 64'h1);
        step(); step(); step();
        dm_req = 1'b0;

        // Both requesting: D, D, IF, D, IF
        step();
        if_req = 1'b1; if_addr = 64'h200;
        dm_req = 1'b1; dm_addr = 64'h300;
        for (int i = 0; i < 5; i++) begin
            if (i == 2 || i == 4) begin
                push(K_IG, 64'h200, 64'h0, 1'b0);
                push(K_IV, 64'h9ABC_DEF0, 64'h0, 1'b0);
            end else begin
                push(K_DG, 64'h300, 64'h0, 1'b0);
                push(K_DV, 64'h0BAD_F00D_CAFE_0001, 64'h0, 1'b0);
            end
        end
        for (int c = 0; c < 15; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (c == 0)
                chk("both_c0_stall_if", 64'(stall_if), 64'h1);
            if (c == 14)
                chk("both_c14_stalls", 64'({stall_if, stall_mem}), 64'h1);
        end
        step();
        if_req = 1'b0; dm_req = 1'b0;

        // Back-to-back data reads
        step();
        dm_req = 1'b1; dm_addr = 64'h300;
        for (int i = 0; i < 3; i++) begin
            push(K_DG, 64'h300, 64'h0, 1'b0);
            push(K_DV, 64'h0BAD_F00D_CAFE_0001, 64'h0, 1'b0);
        end
        for (int c = 0; c < 9; c++) begin
            if (c > 0) step();
            @(negedge clk);
            chk($sformatf("b2b_stall_mem_c%0d", c), 64'(stall_mem),
                (c % 3 == 2) ? 64'h0 : 64'h1);
        end
        step();
        dm_req = 1'b0;

        // Reset aborts an in-flight read
        step();
        dm_req = 1'b1; dm_addr = 64'h300;
        push(K_DG, 64'h300, 64'h0, 1'b0);
        @(negedge clk);
        chk("abort_gnt", 64'(dm_gnt), 64'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_outs", 64'({mem_en, dm_gnt, dm_valid}), 64'h0);
        chk("abort_rst_stall", 64'(stall_mem), 64'h1);
        step();
        @(negedge clk);
        chk("abort_no_valid", 64'(dm_valid), 64'h0);
        chk("abort_rdata", dm_rdata, 64'h0);
        step();
        rst = 1'b0; dm_addr = 64'h308;
        push(K_DG, 64'h308, 64'h0, 1'b0);
        push(K_DV, 64'h1111_2222_3333_4444, 64'h0, 1'b0);
        @(negedge clk);
        chk("post_rst_gnt", 64'(dm_gnt), 64'h1);
        step(); step(); step();
        dm_req = 1'b0;
        step(); step();
        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-002 SHALL have parameter STARVE_MAX, default 4: IF wait-cycle count at which IF gets priority; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch read request, level, held until if_valid.
REQ-006 SHALL have port if_addr, input, 64: fetch byte address, 4-byte aligned.
REQ-007 SHALL have port if_gnt, output, 1: one-cycle pulse when an IF access is issued.
REQ-008 SHALL have port if_rdata, output, 32: fetched instruction word.
REQ-009 SHALL have port if_valid, output, 1: one-cycle pulse qualifying if_rdata.
REQ-010 SHALL have port dm_req, input, 1: data-stage request, level, held until dm_valid.
REQ-011 SHALL have port dm_we, input, 1: 1 = write, 0 = read.
REQ-012 SHALL have port dm_addr, input, 64: data byte address, 8-byte aligned.
REQ-013 SHALL have port dm_wdata, input, 64: store data.
REQ-014 SHALL have port dm_gnt, output, 1: one-cycle pulse when a data access is issued.
REQ-015 SHALL have port dm_rdata, output, 64: load data.
REQ-016 SHALL have port dm_valid, output, 1: one-cycle pulse; completes a read or a write.
REQ-017 SHALL have port mem_en, output, 1: single-port memory access strobe.
REQ-018 SHALL have port mem_we, output, 1: memory write enable, meaningful only with mem_en.
REQ-019 SHALL have port mem_addr, output, 64: memory address with bits [2:0] forced to 0.
REQ-020 SHALL have port mem_wdata, output, 64: memory write data.
REQ-021 SHALL have port mem_rdata, input, 64: memory read data, valid MEM_LAT cycles after mem_en.
REQ-022 SHALL have port stall_if, output, 1: fetch stage must hold (if_req high and no if_valid this cycle).
REQ-023 SHALL have port stall_mem, output, 1: data stage must hold (dm_req high and no dm_valid this cycle).

Function
REQ-024 SHALL use a two-state FSM: IDLE and BUSY; at most one transaction outstanding.
REQ-025 In IDLE with at least one request, SHALL issue in the same cycle (combinational grant): assert mem_en, the winner's gnt, mem_addr, mem_we (dm_we for data, 0 for IF), mem_wdata (dm_wdata for data, 0 for IF); then go to BUSY, latching owner and owner's addr[2].
REQ-026 Arbitration: data port wins by default; IF wins if starve_cnt >= STARVE_MAX.
REQ-027 starve_cnt (4 bits) SHALL increment, saturating at 15, each cycle if_req=1 and IF is not granted; it clears on IF grant or when if_req=0.
REQ-028 BUSY SHALL load a down-counter with MEM_LAT at issue; in the cycle the counter reaches 1 (MEM_LAT cycles after issue), assert the owner's valid for one cycle, then return to IDLE.
REQ-029 No grant SHALL be issued in BUSY, including the valid cycle; the earliest next issue is the cycle after valid (issue-to-issue spacing = MEM_LAT+1).
REQ-030 if_rdata SHALL be mem_rdata[63:32] if latched addr[2]=1, else mem_rdata[31:0]; dm_rdata = mem_rdata; both are 0 when not valid.
REQ-031 A write completes with dm_valid MEM_LAT cycles after issue, the same as a read; dm_rdata is 0 for writes.
REQ-032 Requests from the owner while in BUSY SHALL be ignored; a req still high in the cycle after valid SHALL be treated as a new request.
REQ-033 When mem_en=0, mem_we, mem_addr, and mem_wdata SHALL be 0.
REQ-034 Simultaneous if_req and dm_req with starve_cnt < STARVE_MAX SHALL grant data; IF stays stalled.

Reset
REQ-035 While rst=1, all outputs except stall_if/stall_mem SHALL be 0; state = IDLE; counters = 0.
REQ-036 rst mid-transaction SHALL abort it: no valid is ever produced for it, and late mem_rdata is ignored.
REQ-037 First issue is possible in the first cycle with rst=0.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-038 IF read, if_addr=0x104, mem returns 0xAAAA_BBBB_1111_2222 -> at cycle T: if_gnt=1, mem_addr=0x100; at T+2: if_valid=1, if_rdata=0xAAAABBBB.
REQ-039 dm write addr 0x40, data 0x55 -> at T: mem_en=1, mem_we=1, mem_wdata=0x55; at T+2: dm_valid=1; next issue no earlier than T+3.
REQ-040 if_req and dm_req both held high continuously -> grants: D, D, IF (starve_cnt=4 reached), D, ...; no grant is issued while BUSY.
REQ-041 rst asserted at T+1 of a dm read -> no dm_valid at T+2; all outputs 0; a fresh request after rst is granted on its first cycle.
REQ-042 dm_req only, held 3 transactions back-to-back -> dm_gnt at T, T+3, T+6; stall_mem=1 except in the dm_valid cycles.
